// File: rtl/sm_0535_rx_pkg.sv
// sm_0535_rx_pkg: shared frame-decoder states, delimiters and path-map width.
package sm_0535_rx_pkg;
    localparam int PATH_W = 17;
    localparam logic [7:0] DEF_START = 8'h50;
    localparam logic [7:0] DEF_END = 8'h23;
    typedef enum logic [2:0] {IDLE, PAY0, PAY1, PAY2, CHK, END} state_t;
endpackage

// File: rtl/sm_0535_gap_timer.sv
// sm_0535_gap_timer: inter-byte gap counter with clear, enable and expire.
module sm_0535_gap_timer #(
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (clr || !en) cnt <= '0;
        else if (cnt != LAST) cnt <= cnt + 1'b1;
    end
    // A byte arriving on the expiry cycle takes priority over the abort.
    assign expire = en && !clr && cnt == LAST;
endmodule

// File: rtl/sm_0535_path_frame_decoder.sv
// sm_0535_path_frame_decoder: assembles 6-byte path frames, checks them and
// atomically commits the 17-bit path map; bad or stalled frames are counted.
module sm_0535_path_frame_decoder
    import sm_0535_rx_pkg::*;
#(
    parameter logic [7:0] START_BYTE = DEF_START,
    parameter logic [7:0] END_BYTE = DEF_END,
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    output logic [PATH_W-1:0] paths_av,
    output logic              paths_valid,
    output logic              frame_err,
    output logic [7:0]        err_count,
    output logic              busy
);
    state_t state;
    logic [7:0] b0, b1, b2, c;
    logic expire, good, commit, bad;
    sm_0535_gap_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_gap (
        .clk(clk),
        .rst_n(rst_n),
        .clr(rx_valid),
        .en(state != IDLE),
        .expire(expire)
    );
    assign good = rx_byte == END_BYTE && c == (b0 ^ b1 ^ b2) && b0[7:1] == 7'd0;
    assign commit = rx_valid && state == END && good;
    assign bad = (rx_valid && state == END && !good) || expire;
    assign busy = state != IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            {b0, b1, b2, c} <= '0;
            paths_av <= '0;
            paths_valid <= 1'b0;
            frame_err <= 1'b0;
            err_count <= '0;
        end else begin
            paths_valid <= commit;
            frame_err <= bad;
            if (commit) paths_av <= {b0[0], b1, b2};
            if (bad && err_count != 8'hFF) err_count <= err_count + 1'b1;
            if (rx_valid) begin
                case (state)
                    IDLE: if (rx_byte == START_BYTE) state <= PAY0;
                    PAY0: begin b0 <= rx_byte; state <= PAY1; end
                    PAY1: begin b1 <= rx_byte; state <= PAY2; end
                    PAY2: begin b2 <= rx_byte; state <= CHK; end
                    CHK: begin c <= rx_byte; state <= END; end
                    default: state <= IDLE;
                endcase
            end else if (expire) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_sm_0535_path_frame_decoder.sv
// tb_sm_0535_path_frame_decoder: directed test-plan frames plus a random byte
// stream, checked every cycle against a queue-based frame model.
module tb_sm_0535_path_frame_decoder;
    localparam int TO = 16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] rx_byte = '0;
    logic rx_valid = 1'b0;
    logic [16:0] paths_av;
    logic paths_valid, frame_err, busy;
    logic [7:0] err_count;
    int n_vec = 0;
    int n_bad = 0;
    logic [7:0] m_q[$];
    bit m_in, m_pv, m_fe;
    int m_gap, m_ec;
    logic [16:0] m_paths;

    sm_0535_path_frame_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_byte(rx_byte),
        .rx_valid(rx_valid),
        .paths_av(paths_av),
        .paths_valid(paths_valid),
        .frame_err(frame_err),
        .err_count(err_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_in = 0; m_pv = 0; m_fe = 0; m_gap = 0; m_ec = 0; m_paths = '0;
    endtask

    task automatic model_err();
        m_fe = 1;
        if (m_ec < 255) m_ec++;
    endtask

    // Frame semantics: START opens a frame, the next five bytes are b0 b1 b2 c end.
    task automatic model(input bit v, input logic [7:0] b);
        m_pv = 0;
        m_fe = 0;
        if (v) begin
            m_gap = 0;
            if (!m_in) begin
                if (b == 8'h50) begin m_in = 1; m_q.delete(); end
            end else begin
                m_q.push_back(b);
                if (m_q.size() == 5) begin
                    m_in = 0;
                    if (m_q[4] == 8'h23 && m_q[3] == (m_q[0] ^ m_q[1] ^ m_q[2]) && m_q[0] < 8'd2) begin
                        m_paths = {m_q[0][0], m_q[1], m_q[2]};
                        m_pv = 1;
                    end else model_err();
                end
            end
        end else if (m_in) begin
            m_gap++;
            if (m_gap == TO) begin m_in = 0; model_err(); end
        end
    endtask

    task automatic check_all(input string pfx);
        chk({pfx, ".paths_av"}, 32'(paths_av), 32'(m_paths));
        chk({pfx, ".paths_valid"}, 32'(paths_valid), 32'(m_pv));
        chk({pfx, ".frame_err"}, 32'(frame_err), 32'(m_fe));
        chk({pfx, ".err_count"}, 32'(err_count), 32'(m_ec));
        chk({pfx, ".busy"}, 32'(busy), 32'(m_in));
    endtask

    task automatic step(input bit v, input logic [7:0] b);
        rx_valid = v;
        rx_byte = b;
        @(posedge clk);
        model(v, b);
        #1;
        check_all("cyc");
        rx_valid = 0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        step(1, b);
        repeat (gap) step(0, 8'h00);
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [7:0] d, input logic [7:0] e, input logic [7:0] f);
        send(a, 0); send(b, 0); send(c, 0); send(d, 0); send(e, 0); send(f, 0);
    endtask

    initial begin
        logic [7:0] fb[6];
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1;

        frame(8'h50, 8'h01, 8'hA5, 8'h3C, 8'h98, 8'h23);
        chk("good.paths", 32'(paths_av), 32'h1A53C);
        chk("good.pulse", 32'(paths_valid), 32'd1);
        step(0, 8'h00);
        chk("good.single", 32'(paths_valid), 32'd0);

        frame(8'h50, 8'h00, 8'h00, 8'h01, 8'h00, 8'h23);
        chk("badchk.err", 32'(frame_err), 32'd1);
        chk("badchk.cnt", 32'(err_count), 32'd1);
        chk("badchk.hold", 32'(paths_av), 32'h1A53C);

        frame(8'h50, 8'h02, 8'h00, 8'h00, 8'h02, 8'h23);
        chk("resv.err", 32'(frame_err), 32'd1);
        chk("resv.hold", 32'(paths_av), 32'h1A53C);

        send(8'h50, 0);
        send(8'hFF, TO - 1);
        chk("to.pre_busy", 32'(busy), 32'd1);
        step(0, 8'h00);
        chk("to.err", 32'(frame_err), 32'd1);
        chk("to.busy", 32'(busy), 32'd0);
        frame(8'h50, 8'h00, 8'h12, 8'h34, 8'h26, 8'h23);
        chk("to.next", 32'(paths_av), 32'h01234);

        send(8'h23, 0); send(8'h41, 1); send(8'h00, 0);
        chk("idle.busy", 32'(busy), 32'd0);
        chk("idle.cnt", 32'(err_count), 32'd3);

        for (int n = 0; n < 250; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            fb[0] = 8'h50;
            fb[1] = (kind == 1) ? 8'($urandom) : 8'($urandom_range(0, 1));
            fb[2] = 8'($urandom);
            fb[3] = 8'($urandom);
            fb[4] = fb[1] ^ fb[2] ^ fb[3];
            fb[5] = 8'h23;
            if (kind == 0) fb[$urandom_range(1, 5)] ^= 8'(1 << $urandom_range(0, 7));
            if (kind == 2) repeat ($urandom_range(1, 3)) send(8'($urandom), $urandom_range(0, 2));
            for (int i = 0; i < 6; i++) begin
                int g;
                g = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : 0;
                if (kind == 3 && i == 2) g = $urandom_range(TO - 2, TO + 2);
                send(fb[i], g);
            end
        end

        for (int n = 0; n < 300; n++) frame(8'h50, 8'h00, 8'h00, 8'h01, 8'h00, 8'h23);
        chk("sat.cnt", 32'(err_count), 32'd255);

        send(8'h50, 0); send(8'h01, 0); send(8'hA5, 0);
        #2;
        rst_n = 0;
        model_reset();
        #1;
        check_all("midrst");
        @(posedge clk);
        #1;
        rst_n = 1;
        send(8'h3C, 0); send(8'h98, 0); send(8'h23, 2);
        chk("midrst.cnt", 32'(err_count), 32'd0);
        chk("midrst.paths", 32'(paths_av), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/sm_0535_path_frame_decoder.md
# sm_0535_path_frame_decoder

Framed-command decoder between the UART receiver byte output and the bot core's `path` input. It assembles a fixed 6-byte frame (start, 3 payload, checksum, end) from the received byte stream. It checks framing, reserved bits and an XOR checksum. On a good frame it atomically updates the 17-bit path-availability map. Malformed or stalled frames are discarded and counted, so the core never sees a partially written map.

## Interface
Parameters:
- `START_BYTE`, default 8'h50 ('P'): frame start delimiter.
- `END_BYTE`, default 8'h23 ('#'): frame end delimiter.
- `TIMEOUT_CYCLES`, default 2_500_000 (50 ms at 50 MHz): maximum idle gap between bytes inside a frame.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous assert, active-low reset.
- `rx_byte`  in  8: received byte, sampled only when `rx_valid`=1.
- `rx_valid`  in  1: one-cycle strobe per received byte.
- `paths_av`  out  17: committed path map; bit i=1 means path i is available.
- `paths_valid`  out  1: one-cycle pulse on each commit.
- `frame_err`  out  1: one-cycle pulse on each discarded frame.
- `err_count`  out  8: saturating count of discarded frames.
- `busy`  out  1: high while a frame is in progress (state ≠ IDLE).

## Operation
- Reset values: every output is 0 and the state is IDLE. Payload and checksum registers and the gap timer are all cleared.
- The state machine has six states: IDLE → PAY0 → PAY1 → PAY2 → CHK → END → IDLE. It advances only on `rx_valid`.
- IDLE:
  - `rx_byte`==START_BYTE → PAY0.
  - Any other byte is ignored silently, with no error.
- PAY0:
  - Stores `rx_byte` as b0.
  - Bits b0[7:1] are reserved and must be 0.
  - b0[0] maps to `paths_av[16]`.
- PAY1: stores b1, which maps to `paths_av[15:8]`.
- PAY2: stores b2, which maps to `paths_av[7:0]`.
- CHK: stores the received checksum c.
- END: the frame is good iff all of the following hold:
  - `rx_byte`==END_BYTE;
  - c == b0^b1^b2;
  - b0[7:1]==0.
- Good frame: `paths_av` ← {b0[0],b1,b2} and `paths_valid` pulses.
- Bad frame: `paths_av` is unchanged, `frame_err` pulses and `err_count` increments, saturating at 255.
- Either way the state returns to IDLE.
- Inside a frame, START_BYTE and END_BYTE values are plain data. There is no resynchronisation mid-frame.
- Gap timer:
  - Clears on every `rx_valid`.
  - Counts while state ≠ IDLE.
  - When it reaches TIMEOUT_CYCLES-1 with no `rx_valid`, the frame aborts: state → IDLE, `frame_err` pulses and `err_count` increments.
- Simultaneous `rx_valid` and timeout: the byte wins. It is processed normally and the timer clears.
- The timer is held at 0 in IDLE.

## Timing
- `paths_av` and `paths_valid` are registered. Both change on the edge after the cycle in which the END byte's `rx_valid` is high (1-cycle latency).
- `frame_err` and `err_count` follow the same 1-cycle latency, whether caused by a bad END or by timeout.
- `busy` rises on the edge after a START byte is accepted. It falls on the edge at which the state returns to IDLE.
- Back-to-back `rx_valid` on consecutive cycles is supported with no dropped bytes.
- Reset mid-frame discards the partial frame. The error count is cleared and no `frame_err` is produced.

## Structure
- Shared package `sm_0535_rx_pkg` holds:
  - the state enum (IDLE, PAY0, PAY1, PAY2, CHK, END);
  - the default START/END constants;
  - the path-map width constant (17), reused by the bot core.
- Sub-module `sm_0535_gap_timer`: a counter with clear/enable/expire. It is parameterised by TIMEOUT_CYCLES, with width $clog2(TIMEOUT_CYCLES).

## Test plan
- Good frame: 50 01 A5 3C 98 23.
  - `paths_av`=17'h1A53C one cycle after the END byte.
  - `paths_valid` is a single pulse; `err_count`=0.
- Bad checksum: 50 00 00 01 00 23.
  - `frame_err` pulses; `err_count`=1.
  - `paths_av` holds its prior value; no `paths_valid`.
- Reserved bit set: 50 02 00 00 02 23 → one `frame_err`, `paths_av` unchanged.
- Timeout:
  - Stimulus: 50 FF, then a gap of TIMEOUT_CYCLES (shortened parameter, e.g. 16).
  - `frame_err` pulses at expiry and `busy` drops.
  - A following good frame 50 00 12 34 26 23 → `paths_av`=17'h01234.
- Idle garbage and saturation:
  - 23 41 00 in IDLE → no error, `busy` stays 0.
  - 300 bad frames → `err_count` stops at 255.
- Reset mid-frame:
  - Assert `rst_n` after 50 01 A5; all outputs go to 0.
  - Then 3C 98 23 → ignored, with no `paths_valid` and no error.
